// File: rtl/align_shifter_pkg.sv
// Shared definitions for the FMA alignment front end.
//   MANT_W       : significand width, hidden bit included
//   EXT_W        : extended mantissa width {significand, G, R, S}
//   G/R/S_BIT    : positions of guard, round and sticky in the extended mantissa
//   CNT_W        : width of the remaining-shift counter (holds 0..EXT_W)
//   align_state_t: control states of the iterative shifter
package align_shifter_pkg;

  localparam int MANT_W = 24;
  localparam int EXT_W  = MANT_W + 3;
  localparam int G_BIT  = 2;
  localparam int R_BIT  = 1;
  localparam int S_BIT  = 0;
  localparam int CNT_W  = $clog2(EXT_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;

endpackage

// File: rtl/align_shifter_sticky_shift_step.sv
// One combinational step of the sticky right shift (sticky_shift_step).
//   din  : EXT_W-bit extended mantissa, bit0 already holds accumulated sticky
//   amt  : shift amount 0..STEP
//   dout : din >> amt, with bit0 = OR of din[amt:0]
module align_shifter_sticky_shift_step
  import align_shifter_pkg::*;
#(
  parameter  int STEP  = 4,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  logic [EXT_W-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic [EXT_W-1:0] dout
);

  logic sticky;

  // NOTE: every signal written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dout   = din >> amt;
    sticky = 1'b0;
    // Bits [amt-1:0] fall off the end; bit amt lands in bit0. The old bit0
    // is already sticky, so all of din[amt:0] fold into the new sticky.
    for (int i = 0; i < EXT_W; i++) begin
      if (i <= int'(amt)) sticky = sticky | din[i];
    end
    dout[S_BIT] = sticky;
  end

endmodule

// File: rtl/align_shifter.sv
// Iterative alignment shifter in front of the FMA rounder.
// Right-shifts a 24-bit significand by min(shamt, 27) into the 27-bit
// {significand, G, R, S} format, at most STEP bits per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   m_in, shamt, e_in   : significand, shift amount, exponent tag
//   out_valid/out_ready : result handshake (valid only in DONE)
//   m_out, e_out        : aligned extended mantissa, registered exponent tag
//   busy                : a request is in flight
module align_shifter
  import align_shifter_pkg::*;
#(
  parameter int STEP = 4,
  parameter int SH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] m_in,
  input  logic [SH_W-1:0]   shamt,
  input  logic [7:0]        e_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXT_W-1:0]  m_out,
  output logic [7:0]        e_out,
  output logic              busy
);

  localparam int AMT_W = $clog2(STEP + 1);

  align_state_t     state, state_next;
  logic [EXT_W-1:0] acc, step_in, step_out;
  logic [CNT_W-1:0] cnt, n_sat, remain, cnt_next;
  logic [AMT_W-1:0] amt;
  logic [7:0]       e_q;
  logic             accept;

  // Anything shifted 27 or more places leaves only sticky, so saturate.
  always_comb begin
    if (32'(shamt) >= 32'(EXT_W)) n_sat = CNT_W'(EXT_W);
    else                          n_sat = CNT_W'(shamt);
  end

  assign accept = in_valid && (state == IDLE);

  // The first step is applied to the incoming value in the accept cycle, so
  // a request needing at most STEP bits is ready one cycle later and each
  // further STEP bits cost one SHIFT cycle.
  assign remain   = (state == IDLE) ? n_sat : cnt;
  assign step_in  = (state == IDLE) ? {m_in, {(EXT_W - MANT_W){1'b0}}} : acc;
  assign amt      = (32'(remain) > STEP) ? AMT_W'(STEP) : AMT_W'(remain);
  assign cnt_next = remain - CNT_W'(amt);

  align_shifter_sticky_shift_step #(.STEP(STEP)) u_step (
    .din  (step_in),
    .amt  (amt),
    .dout (step_out)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = (cnt_next == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_next == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the FSM so m_out and
  // e_out read as zero after reset instead of holding stale data.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      e_q   <= '0;
    end else begin
      state <= state_next;
      if (accept || state == SHIFT) begin
        acc <= step_out;
        cnt <= cnt_next;
      end
      if (accept) e_q <= e_in;
    end
  end

  assign m_out = acc;
  assign e_out = e_q;

endmodule

// File: tb/tb_align_shifter.sv
module tb_align_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] m_in;
  logic [7:0]  shamt;
  logic [7:0]  e_in;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [26:0] m_out     [3];
  logic [7:0]  e_out     [3];
  logic        busy      [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  align_shifter #(.STEP(1), .SH_W(8)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .m_in(m_in), .shamt(shamt), .e_in(e_in), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .m_out(m_out[0]), .e_out(e_out[0]), .busy(busy[0]));

  align_shifter #(.STEP(4), .SH_W(8)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .m_in(m_in), .shamt(shamt), .e_in(e_in), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .m_out(m_out[1]), .e_out(e_out[1]), .busy(busy[1]));

  align_shifter #(.STEP(27), .SH_W(8)) u_s27 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .m_in(m_in), .shamt(shamt), .e_in(e_in), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .m_out(m_out[2]), .e_out(e_out[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 27;
  endfunction

  function automatic int sat_n(input int sh);
    return (sh >= 27) ? 27 : sh;
  endfunction

  // One full-width shift of the padded significand; every bit that drops
  // off the bottom is folded into the sticky position.
  function automatic logic [26:0] ref_shift(input logic [23:0] m, input int sh);
    longint unsigned v, r, lost;
    int n;
    n    = sat_n(sh);
    v    = longint'(m) * 8;
    r    = v >> n;
    lost = v & ((64'd1 << n) - 64'd1);
    if (lost != 0) r = r | 64'd1;
    return r[26:0];
  endfunction

  function automatic int ref_latency(input int sh, input int step);
    int n;
    n = sat_n(sh);
    return (n == 0) ? 1 : (n + step - 1) / step;
  endfunction

  task automatic check_idle(input int k, input string tag);
    check({tag, "_in_ready"},  32'(in_ready[k]),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid[k]), 32'd0);
    check({tag, "_busy"},      32'(busy[k]),      32'd0);
  endtask

  task automatic txn(input int k, input logic [23:0] m, input int sh,
                     input logic [7:0] e, input int hold);
    logic [26:0] exp_m;
    int lat;
    exp_m = ref_shift(m, sh);
    @(negedge clk);
    m_in = m; shamt = 8'(sh); e_in = e; in_valid[k] = 1'b1;
    check("in_ready_before", 32'(in_ready[k]), 32'd1);
    @(posedge clk); #1;
    // Inputs wiggle after the accept edge and must not disturb the result.
    in_valid[k] = 1'b0; m_in = 24'($urandom); shamt = 8'($urandom); e_in = 8'($urandom);
    check("in_ready_after", 32'(in_ready[k]), 32'd0);
    check("busy_after", 32'(busy[k]), 32'd1);
    lat = 1;
    while (!out_valid[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency_k%0d_sh%0d", k, sh), 32'(lat), 32'(ref_latency(sh, step_of(k))));
    check($sformatf("m_out_k%0d_sh%0d", k, sh), 32'(m_out[k]), 32'(exp_m));
    check("e_out", 32'(e_out[k]), 32'(e));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid[k]), 32'd1);
      check("hold_m_out", 32'(m_out[k]), 32'(exp_m));
      check("hold_e_out", 32'(e_out[k]), 32'(e));
      check("hold_in_ready", 32'(in_ready[k]), 32'd0);
    end
    @(negedge clk);
    out_ready[k] = 1'b1;
    check("in_ready_not_comb", 32'(in_ready[k]), 32'd0);
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check_idle(k, "release");
  endtask

  initial begin
    rst = 1'b1; m_in = '0; shamt = '0; e_in = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_idle(k, "reset");
      check("reset_m_out", 32'(m_out[k]), 32'd0);
      check("reset_e_out", 32'(e_out[k]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // Directed cases on the STEP=4 instance.
    txn(1, 24'h800000, 0, 8'h7F, 0);
    check("t1_const", 32'(ref_shift(24'h800000, 0)), 32'h4000000);
    txn(1, 24'h800000, 3, 8'h11, 0);
    txn(1, 24'hC00001, 5, 8'h22, 5);
    check("t3_const", 32'(ref_shift(24'hC00001, 5)), 32'h0300001);
    txn(1, 24'h000001, 255, 8'h33, 0);
    txn(1, 24'h000000, 255, 8'h44, 0);
    txn(1, 24'h000000, 13, 8'h45, 0);

    // Shift sweep across every instance, plus random large shift amounts.
    for (int k = 0; k < 3; k++) begin
      for (int sh = 0; sh <= 40; sh++) txn(k, 24'($urandom), sh, 8'($urandom), 0);
      for (int j = 0; j < 6; j++)
        txn(k, 24'($urandom), int'($urandom_range(0, 255)), 8'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a SHIFT sequence.
    @(negedge clk);
    m_in = 24'hABCDEF; shamt = 8'd20; e_in = 8'h5A; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy[1]), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_idle(1, "mid_reset");
    check("mid_reset_m_out", 32'(m_out[1]), 32'd0);
    check("mid_reset_e_out", 32'(e_out[1]), 32'd0);
    @(negedge clk); rst = 1'b0;
    txn(1, 24'hFFFFFF, 1, 8'h66, 0);
    check("t6_const", 32'(ref_shift(24'hFFFFFF, 1)), 32'h3FFFFFC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
